booth_result_display: RTL and testbench
=======================================

// Module: booth_result_display
// PURPOSE
//  Downstream consumer of the sequential Booth multiplier.
//  - Captures the signed 8-bit product on each DONE pulse.
//  - Converts it to sign + three BCD digits with a sequential double-dabble, one iteration per cycle.
//  - Drives a 4-digit multiplexed, active-low 7-segment display on the board.
// PARAMETERS
//  REFRESH_W   16   width of the display refresh counter; the top 2 bits select the active digit
// PORTS
//  clk   in   1   system clock; all state updates on its rising edge
//  rst   in   1   asynchronous, active-high reset
//  done  in   1   one-cycle pulse from the multiplier; prod is valid in the same cycle
//  prod  in   8   two's-complement product, range -128..+127
//  busy  out  1   high while a conversion is in progress (LOAD or SHIFT)
//  an    out  4   digit enables, active-low; an[3] is the sign digit, an[0] the ones digit
//  seg   out  7   segments {g,f,e,d,c,b,a}, active-low
// BEHAVIOUR
//  Clock and reset: one clock; reset is asynchronous and active-high.
//  Reset values:
//   - FSM=IDLE, busy=0, pending=0, refresh counter=0.
//   - Digit registers: sign=0, hundreds/tens/ones=0.
//   - an=4'b1110 (ones digit selected), seg shows '0' (7'b1000000).
//  FSM states: IDLE, LOAD, SHIFT.
//   - IDLE:  done=1 -> capture prod, go to LOAD.
//   - LOAD:  sign<=prod[7]; mag<=|prod| (-128 -> 8'd128 unsigned); scratch BCD<=0; iter<=0; go to SHIFT.
//   - SHIFT: each cycle, add 3 to any BCD nibble >=5, then shift {bcd,mag} left by 1; iter++.
//            After the 8th shift, load the digit registers atomically, then go to IDLE, or to LOAD if pending=1.
//  Latency: done at cycle N -> LOAD at N+1 -> digit registers updated at the edge ending cycle N+9.
//   busy=1 for exactly 9 cycles per conversion.
//  done while busy: latch prod into the pending buffer (1 deep) and set pending=1.
//   A later done overwrites the buffer, so the newest value wins.
//   Pending is cleared when its conversion enters LOAD.
//  done in the same cycle SHIFT finishes: pending path applies (LOAD next cycle, with the new value).
//  Display registers hold the last completed result; they never show partial conversion data.
//  Refresh: counter free-runs and wraps at 2^REFRESH_W. sel=cnt[REFRESH_W-1:REFRESH_W-2].
//   Only an[sel] is driven low; an and seg are registered, with no glitch between digits.
//  Digit 3: '-' (segment g only, 7'b0111111) when sign=1, otherwise blank (7'b1111111).
//  Digit codes 0..9 use the standard encoding; BCD values >9 cannot occur (range is 0..128).
//  Reset mid-conversion: aborts immediately, drops any pending value, and restores the reset values.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN
//   - defined: hundreds digit blank if 0; tens digit blank if hundreds=0 and tens=0; ones never blanked.
//     Example: -5 displays as "-  5".
//   - undefined: all three magnitude digits always shown. Example: -5 displays as "-005".
//   - Sign-digit behaviour is identical in both builds.
// STRUCTURE
//  Shared package booth_disp_pkg:
//   - 7-segment code constants (SEG_0..SEG_9, SEG_MINUS, SEG_BLANK).
//   - FSM state encodings (ST_IDLE, ST_LOAD, ST_SHIFT).
//  Sub-module bin2bcd_seq: start/mag in; bcd[11:0]/valid out; implements LOAD/SHIFT iteration.
//  Top level holds the capture/pending logic, digit registers and refresh/segment mux.
// TESTING
//  T1 reset: rst pulse -> an=1110, seg=1000000, busy=0; with _EN the display shows "   0".
//  T2 prod=8'h0F (+15), done pulse -> busy=1 for 9 cycles; digits 0,1,5; sign blank.
//  T3 prod=8'h80 (-128) -> '-' on digit 3, digits 1,2,8; prod=8'hFF (-1) -> "-  1" (_EN) / "-001".
//  T4 done with +3, then done with +7 and +9 during busy -> final display shows 9; exactly 2 conversions.
//  T5 rst asserted mid-SHIFT (iteration 4) -> immediate reset values; no later digit update.
//  T6 REFRESH_W=4: an cycles 1110,1101,1011,0111 every 4 clocks, with exactly one digit low at a time.

Source files
------------

// File: rtl/booth_disp_pkg.sv
// Shared constants for the Booth product display: 7-segment codes, FSM states
// and the digit encoder.
package booth_disp_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT} state_t;

    // Segment order {g,f,e,d,c,b,a}; a 0 lights the segment
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: signed 8-bit in, sign + 3 BCD digits out after
// one LOAD and eight SHIFT cycles. o_valid marks the final SHIFT cycle.
module bin2bcd_seq
    import booth_disp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [7:0]  i_prod,
    output logic        o_busy,
    output logic        o_valid,
    output logic        o_sign,
    output logic [11:0] o_bcd
);

    state_t      r_state;
    logic [7:0]  r_prod;
    logic [7:0]  r_mag;
    logic [11:0] r_bcd;
    logic [2:0]  r_iter;
    logic        r_sign;

    logic [11:0] w_adj;
    logic [11:0] w_bcd_nxt;

    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < 3; i++) begin
            if (r_bcd[i*4 +: 4] >= 4'd5)
                w_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
        end
    end

    assign w_bcd_nxt = {w_adj[10:0], r_mag[7]};
    assign o_busy    = (r_state != ST_IDLE);
    assign o_valid   = (r_state == ST_SHIFT) && (r_iter == 3'd7);
    assign o_sign    = r_sign;
    // Final shift result goes straight out so the caller can latch it on this edge
    assign o_bcd     = w_bcd_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_prod  <= '0;
            r_mag   <= '0;
            r_bcd   <= '0;
            r_iter  <= '0;
            r_sign  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_prod  <= i_prod;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_sign  <= r_prod[7];
                    // -128 negates to 8'h80, which is 128 read as unsigned
                    r_mag   <= r_prod[7] ? (~r_prod + 8'd1) : r_prod;
                    r_bcd   <= '0;
                    r_iter  <= '0;
                    r_state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    r_bcd  <= w_bcd_nxt;
                    r_mag  <= {r_mag[6:0], 1'b0};
                    r_iter <= r_iter + 3'd1;
                    if (r_iter == 3'd7) begin
                        if (i_start) begin
                            r_prod  <= i_prod;
                            r_state <= ST_LOAD;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/booth_result_display.sv
// Captures Booth products, converts them to decimal and drives a 4-digit
// multiplexed 7-segment display. Optional LEADING_ZERO_BLANK_EN blanks leading zeros.
module booth_result_display
    import booth_disp_pkg::*;
#(
    parameter int REFRESH_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       done,
    input  logic [7:0] prod,
    output logic       busy,
    output logic [3:0] an,
    output logic [6:0] seg
);

    logic                 w_busy, w_valid, w_sign, w_start;
    logic [11:0]          w_bcd;
    logic [7:0]           w_sval;
    logic [REFRESH_W-1:0] w_cnt_nxt;
    logic [1:0]           w_sel;
    logic [6:0]           w_seg_nxt;

    logic                 r_pend;
    logic [7:0]           r_pbuf;
    logic                 r_sign;
    logic [3:0]           r_hund, r_tens, r_ones;
    logic [REFRESH_W-1:0] r_cnt;
    logic [3:0]           r_an;
    logic [6:0]           r_seg;

    // A done arriving on the finishing cycle beats the buffered value: it is newer
    assign w_start = w_busy ? (w_valid && (done || r_pend)) : done;
    assign w_sval  = (w_busy && !done) ? r_pbuf : prod;

    bin2bcd_seq u_bcd (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_start),
        .i_prod  (w_sval),
        .o_busy  (w_busy),
        .o_valid (w_valid),
        .o_sign  (w_sign),
        .o_bcd   (w_bcd)
    );

    assign busy = w_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= 1'b0;
            r_pbuf <= '0;
            r_sign <= 1'b0;
            r_hund <= '0;
            r_tens <= '0;
            r_ones <= '0;
        end else begin
            if (w_busy && w_valid) begin
                r_pend <= 1'b0;
            end else if (w_busy && done) begin
                r_pend <= 1'b1;
                r_pbuf <= prod;
            end
            if (w_valid) begin
                r_sign <= w_sign;
                r_hund <= w_bcd[11:8];
                r_tens <= w_bcd[7:4];
                r_ones <= w_bcd[3:0];
            end
        end
    end

    // an/seg are decoded from the next count so they stay aligned with r_cnt
    assign w_cnt_nxt = r_cnt + 1'b1;
    assign w_sel     = w_cnt_nxt[REFRESH_W-1 -: 2];

    always_comb begin
        w_seg_nxt = SEG_BLANK;
        case (w_sel)
            2'd0: w_seg_nxt = seg_of(r_ones);
            2'd1: begin
`ifdef LEADING_ZERO_BLANK_EN
                w_seg_nxt = (r_hund == 4'd0 && r_tens == 4'd0) ? SEG_BLANK : seg_of(r_tens);
`else
                w_seg_nxt = seg_of(r_tens);
`endif
            end
            2'd2: begin
`ifdef LEADING_ZERO_BLANK_EN
                w_seg_nxt = (r_hund == 4'd0) ? SEG_BLANK : seg_of(r_hund);
`else
                w_seg_nxt = seg_of(r_hund);
`endif
            end
            default: w_seg_nxt = r_sign ? SEG_MINUS : SEG_BLANK;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_an  <= 4'b1110;
            r_seg <= SEG_0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_an  <= ~(4'b0001 << w_sel);
            r_seg <= w_seg_nxt;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;

endmodule

// File: tb/tb_booth_result_display.sv
// Directed bench for booth_result_display with a 4-bit refresh counter;
// expected digits follow the LEADING_ZERO_BLANK_EN build setting.
module tb_booth_result_display;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SM = 7'b0111111;
    localparam logic [6:0] SB = 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ = SB;
`else
    localparam logic [6:0] LZ = S0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       done = 1'b0;
    logic [7:0] prod = 8'h00;
    logic       busy;
    logic [3:0] an;
    logic [6:0] seg;

    int n_pass = 0;
    int n_tot  = 0;
    int nb;

    booth_result_display #(.REFRESH_W(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .done (done),
        .prod (prod),
        .busy (busy),
        .an   (an),
        .seg  (seg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_digit(input int d, input logic [6:0] exp, input string tag);
        logic [3:0] mask;
        mask = ~(4'b0001 << d);
        for (int k = 0; k < 24; k++) begin
            if (an === mask) break;
            @(negedge clk);
        end
        chk({tag, "_an"}, {28'd0, an}, {28'd0, mask});
        chk(tag, {25'd0, seg}, {25'd0, exp});
    endtask

    // Launch p0, optionally inject extra done pulses at busy-cycle ka/kb,
    // and return the number of cycles busy stayed high.
    task automatic burst(input logic [7:0] p0, input int ka, input logic [7:0] pa,
                         input int kb, input logic [7:0] pb, output int n);
        done = 1'b1; prod = p0;
        @(negedge clk);
        done = 1'b0;
        n = 0;
        for (int k = 1; k < 60; k++) begin
            if (!busy) break;
            n++;
            done = (k == ka) || (k == kb);
            prod = (k == kb) ? pb : pa;
            @(negedge clk);
        end
        done = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        // T1 reset state
        repeat (3) @(negedge clk);
        chk("t1_an", {28'd0, an}, 32'hE);
        chk("t1_seg", {25'd0, seg}, {25'd0, S0});
        chk("t1_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        check_digit(3, SB, "t1_d3");
        check_digit(2, LZ, "t1_d2");
        check_digit(1, LZ, "t1_d1");
        check_digit(0, S0, "t1_d0");

        // T2 +15, busy exactly 9 cycles
        burst(8'h0F, 0, 8'h00, 0, 8'h00, nb);
        chk("t2_busy_cycles", nb, 32'd9);
        check_digit(3, SB, "t2_d3");
        check_digit(2, LZ, "t2_d2");
        check_digit(1, S1, "t2_d1");
        check_digit(0, S5, "t2_d0");

        // T3 -128 and -1
        burst(8'h80, 0, 8'h00, 0, 8'h00, nb);
        check_digit(3, SM, "t3a_d3");
        check_digit(2, S1, "t3a_d2");
        check_digit(1, S2, "t3a_d1");
        check_digit(0, S8, "t3a_d0");
        burst(8'hFF, 0, 8'h00, 0, 8'h00, nb);
        check_digit(3, SM, "t3b_d3");
        check_digit(2, LZ, "t3b_d2");
        check_digit(1, LZ, "t3b_d1");
        check_digit(0, S1, "t3b_d0");

        // T4 +3, then +7 and +9 while busy: newest pending wins, two conversions
        burst(8'd3, 2, 8'd7, 4, 8'd9, nb);
        chk("t4_busy_cycles", nb, 32'd18);
        check_digit(3, SB, "t4_d3");
        check_digit(1, LZ, "t4_d1");
        check_digit(0, S9, "t4_d0");

        // done on the finishing SHIFT cycle chains straight into a new LOAD
        burst(8'd5, 9, 8'd42, 0, 8'd0, nb);
        chk("t4b_busy_cycles", nb, 32'd18);
        check_digit(2, LZ, "t4b_d2");
        check_digit(1, S4, "t4b_d1");
        check_digit(0, S2, "t4b_d0");

        // T5 reset during SHIFT iteration 4 of a +100 conversion
        done = 1'b1; prod = 8'd100;
        @(negedge clk);
        done = 1'b0;
        repeat (5) @(negedge clk);
        chk("t5_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_an", {28'd0, an}, 32'hE);
        chk("t5_seg", {25'd0, seg}, {25'd0, S0});
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("t5_busy_after", {31'd0, busy}, 32'd0);
        check_digit(3, SB, "t5_d3");
        check_digit(2, LZ, "t5_d2");
        check_digit(1, LZ, "t5_d1");
        check_digit(0, S0, "t5_d0");

        // T6 scan order, four clocks per digit
        for (int k = 0; k < 24; k++) begin
            if (an === 4'b0111) break;
            @(negedge clk);
        end
        for (int k = 0; k < 8; k++) begin
            if (an !== 4'b0111) break;
            @(negedge clk);
        end
        for (int i = 0; i < 16; i++) begin
            chk("t6_an", {28'd0, an}, {28'd0, ~(4'b0001 << (i / 4))});
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
